pipe_reg_mw_skid: RTL and testbench

- Parametrised next-generation memory-to-writeback pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Writeback stalls no longer need a global stall wire or lose in-flight instructions.
- Adds flush, commit gating, x0-write suppression and a saturating bubble counter for performance monitoring.
- Sits between the memory stage and the writeback/commit logic of the 64-bit core.

---
 rtl/pipe_reg_mw_skid_pkg.sv | 29 ++
 rtl/pipe_reg_mw_skid_skid_buf_2.sv | 60 ++++++
 rtl/pipe_reg_mw_skid.sv | 82 ++++++++
 tb/tb_pipe_reg_mw_skid.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_mw_skid_pkg.sv
// Shared encodings and payload layout for the memory-to-writeback pipeline register.
package pipe_reg_mw_skid_pkg;

    localparam int unsigned MW_XLEN  = 64;
    localparam int unsigned MW_ILEN  = 32;
    localparam int unsigned MW_RD_W  = 5;
    localparam int unsigned MW_SEL_W = 2;

    localparam logic [MW_SEL_W-1:0] WB_VALD_SEL_VALE = 2'd0;
    localparam logic [MW_SEL_W-1:0] WB_VALD_SEL_VALM = 2'd1;
    localparam logic [MW_SEL_W-1:0] WB_VALD_SEL_PC   = 2'd2;

    localparam logic REG_WEN_NO_W = 1'b0;
    localparam logic REG_WEN_W    = 1'b1;

    typedef struct packed {
        logic                wen;
        logic [MW_RD_W-1:0]  rd;
        logic [MW_SEL_W-1:0] sel;
        logic [MW_XLEN-1:0]  val_e;
        logic [MW_XLEN-1:0]  val_m;
        logic [MW_XLEN-1:0]  pc;
        logic [MW_ILEN-1:0]  instr;
        logic [MW_XLEN-1:0]  pre_pc;
    } mw_payload_t;

    localparam int unsigned MW_PAYLOAD_W = $bits(mw_payload_t);

endpackage

// File: rtl/pipe_reg_mw_skid_skid_buf_2.sv
// Generic two-entry skid buffer: main slot drives the output, skid slot absorbs one stalled input.
module skid_buf_2 #(
    parameter int unsigned      W       = 8,
    parameter logic [W-1:0]     RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         fire;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign accept    = in_valid & !skid_valid;
    assign fire      = main_valid & out_ready;

    // Flush drops valids only; payload registers keep their last contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= RST_VAL;
            skid_data  <= RST_VAL;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || fire) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                skid_valid <= accept;
                if (accept) begin
                    skid_data <= in_data;
                end
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_data <= in_data;
                end
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/pipe_reg_mw_skid.sv
// Memory-to-writeback pipeline register: skid-buffered handshake, x0 write gating,
// commit strobe and a saturating bubble counter.
module pipe_reg_mw_skid
    import pipe_reg_mw_skid_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned RD_W  = 5,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_wb_reg_wen,
    input  logic [RD_W-1:0]  in_wb_rd,
    input  logic [SEL_W-1:0] in_wb_valD_sel,
    input  logic [XLEN-1:0]  in_valE,
    input  logic [XLEN-1:0]  in_valM,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [ILEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pre_pc,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_wb_reg_wen,
    output logic [RD_W-1:0]  out_wb_rd,
    output logic [SEL_W-1:0] out_wb_valD_sel,
    output logic [XLEN-1:0]  out_valE,
    output logic [XLEN-1:0]  out_valM,
    output logic [XLEN-1:0]  out_pc,
    output logic [ILEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pre_pc,
    output logic             out_commit,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int unsigned LOW_W = 4 * XLEN + ILEN;
    localparam int unsigned PW    = 1 + RD_W + SEL_W + LOW_W;
    // Reset payload is all zeros except the writeback select, which points at valE.
    localparam logic [PW-1:0] RST_PAYLOAD =
        {1'b0, RD_W'(0), SEL_W'(WB_VALD_SEL_VALE), LOW_W'(0)};

    logic [PW-1:0] in_payload;
    logic [PW-1:0] main_payload;
    logic          main_wen;

    assign in_payload = {in_wb_reg_wen, in_wb_rd, in_wb_valD_sel,
                         in_valE, in_valM, in_pc, in_instr, in_pre_pc};

    skid_buf_2 #(
        .W       (PW),
        .RST_VAL (RST_PAYLOAD)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (main_payload)
    );

    assign {main_wen, out_wb_rd, out_wb_valD_sel,
            out_valE, out_valM, out_pc, out_instr, out_pre_pc} = main_payload;

    assign out_wb_reg_wen = (main_wen == REG_WEN_W) & out_valid & (out_wb_rd != RD_W'(0));
    assign out_commit     = out_valid & out_ready;

    // Saturating count of empty output cycles; flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_reg_mw_skid.sv
// Directed bench for pipe_reg_mw_skid: vector table plus reset-mid-stall and bubble saturation.
module tb_pipe_reg_mw_skid;
    import pipe_reg_mw_skid_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_wb_reg_wen = 1'b0;
    logic [4:0]  in_wb_rd = '0;
    logic [1:0]  in_wb_valD_sel = '0;
    logic [63:0] in_valE = '0, in_valM = '0, in_pc = '0, in_pre_pc = '0;
    logic [31:0] in_instr = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_wb_reg_wen, out_commit;
    logic [4:0]  out_wb_rd;
    logic [1:0]  out_wb_valD_sel;
    logic [63:0] out_valE, out_valM, out_pc, out_pre_pc;
    logic [31:0] out_instr, bubble_cnt;

    logic        in_ready4, out_valid4, out_wb_reg_wen4, out_commit4;
    logic [4:0]  out_wb_rd4;
    logic [1:0]  out_wb_valD_sel4;
    logic [63:0] out_valE4, out_valM4, out_pc4, out_pre_pc4;
    logic [31:0] out_instr4;
    logic [3:0]  bubble_cnt4;

    always #5 clk = ~clk;

    pipe_reg_mw_skid dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_reg_wen(in_wb_reg_wen), .in_wb_rd(in_wb_rd), .in_wb_valD_sel(in_wb_valD_sel),
        .in_valE(in_valE), .in_valM(in_valM), .in_pc(in_pc), .in_instr(in_instr),
        .in_pre_pc(in_pre_pc), .out_ready(out_ready), .out_valid(out_valid),
        .out_wb_reg_wen(out_wb_reg_wen), .out_wb_rd(out_wb_rd),
        .out_wb_valD_sel(out_wb_valD_sel), .out_valE(out_valE), .out_valM(out_valM),
        .out_pc(out_pc), .out_instr(out_instr), .out_pre_pc(out_pre_pc),
        .out_commit(out_commit), .bubble_cnt(bubble_cnt)
    );

    pipe_reg_mw_skid #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .in_wb_reg_wen(in_wb_reg_wen), .in_wb_rd(in_wb_rd), .in_wb_valD_sel(in_wb_valD_sel),
        .in_valE(in_valE), .in_valM(in_valM), .in_pc(in_pc), .in_instr(in_instr),
        .in_pre_pc(in_pre_pc), .out_ready(out_ready), .out_valid(out_valid4),
        .out_wb_reg_wen(out_wb_reg_wen4), .out_wb_rd(out_wb_rd4),
        .out_wb_valD_sel(out_wb_valD_sel4), .out_valE(out_valE4), .out_valM(out_valM4),
        .out_pc(out_pc4), .out_instr(out_instr4), .out_pre_pc(out_pre_pc4),
        .out_commit(out_commit4), .bubble_cnt(bubble_cnt4)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [63:0] pc;
        logic        wen;
        logic [4:0]  rd;
        logic        ev;
        logic        eir;
        logic        ecm;
        logic [63:0] epc;
        logic [4:0]  erd;
        logic        ewen;
    } vec_t;

    localparam int NV = 21;
    vec_t vec [NV];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Payload fields are derived from the pc so every field is checked against the bench's own model.
    function automatic logic [31:0] f_instr(input logic [63:0] pc);
        return pc[31:0] ^ 32'hDEAD_0000;
    endfunction
    function automatic logic [63:0] f_pre(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction
    function automatic logic [63:0] f_vale(input logic [63:0] pc);
        return ~pc;
    endfunction
    function automatic logic [63:0] f_valm(input logic [63:0] pc);
        return {pc[31:0], pc[63:32]};
    endfunction
    function automatic logic [1:0] f_sel(input logic [63:0] pc);
        return pc[3:2];
    endfunction

    function automatic vec_t mk(input logic fl, input logic iv, input logic ordy,
                                input logic [63:0] pc, input logic wen, input logic [4:0] rd,
                                input logic ev, input logic eir, input logic ecm,
                                input logic [63:0] epc, input logic [4:0] erd, input logic ewen);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc; v.wen = wen; v.rd = rd;
        v.ev = ev; v.eir = eir; v.ecm = ecm; v.epc = epc; v.erd = erd; v.ewen = ewen;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ordy,
                         input logic [63:0] pc, input logic wen, input logic [4:0] rd);
        flush = fl; in_valid = iv; out_ready = ordy; in_pc = pc;
        in_wb_reg_wen = wen; in_wb_rd = rd;
        in_instr = f_instr(pc); in_pre_pc = f_pre(pc);
        in_valE = f_vale(pc); in_valM = f_valm(pc); in_wb_valD_sel = f_sel(pc);
    endtask

    initial begin
        //            fl iv o  pc        wen rd   ev eir cm epc      erd ewen
        vec[0]  = mk(0, 1, 1, 64'h100, 1, 3,   0, 1, 0, 64'h0,   0, 0);
        vec[1]  = mk(0, 1, 1, 64'h104, 1, 3,   1, 1, 1, 64'h100, 3, 1);
        vec[2]  = mk(0, 1, 1, 64'h108, 0, 7,   1, 1, 1, 64'h104, 3, 1);
        vec[3]  = mk(0, 0, 1, 64'h0,   0, 0,   1, 1, 1, 64'h108, 7, 0);
        vec[4]  = mk(0, 0, 1, 64'h0,   0, 0,   0, 1, 0, 64'h0,   0, 0);
        vec[5]  = mk(0, 1, 0, 64'h200, 1, 2,   0, 1, 0, 64'h0,   0, 0);
        vec[6]  = mk(0, 1, 0, 64'h204, 1, 4,   1, 1, 0, 64'h200, 2, 1);
        vec[7]  = mk(0, 1, 0, 64'h208, 1, 6,   1, 0, 0, 64'h200, 2, 1);
        vec[8]  = mk(0, 0, 1, 64'h0,   0, 0,   1, 0, 1, 64'h200, 2, 1);
        vec[9]  = mk(0, 0, 1, 64'h0,   0, 0,   1, 1, 1, 64'h204, 4, 1);
        vec[10] = mk(0, 0, 1, 64'h0,   0, 0,   0, 1, 0, 64'h0,   0, 0);
        vec[11] = mk(0, 1, 1, 64'h400, 1, 0,   0, 1, 0, 64'h0,   0, 0);
        vec[12] = mk(0, 1, 1, 64'h404, 1, 5,   1, 1, 1, 64'h400, 0, 0);
        vec[13] = mk(0, 0, 1, 64'h0,   0, 0,   1, 1, 1, 64'h404, 5, 1);
        vec[14] = mk(0, 0, 1, 64'h0,   0, 0,   0, 1, 0, 64'h0,   0, 0);
        vec[15] = mk(0, 1, 0, 64'h500, 1, 1,   0, 1, 0, 64'h0,   0, 0);
        vec[16] = mk(0, 1, 0, 64'h504, 1, 1,   1, 1, 0, 64'h500, 1, 1);
        vec[17] = mk(1, 1, 1, 64'h300, 1, 1,   1, 0, 1, 64'h500, 1, 1);
        vec[18] = mk(0, 0, 1, 64'h0,   0, 0,   0, 1, 0, 64'h0,   0, 0);
        vec[19] = mk(1, 1, 1, 64'h310, 1, 1,   0, 1, 0, 64'h0,   0, 0);
        vec[20] = mk(0, 0, 1, 64'h0,   0, 0,   0, 1, 0, 64'h0,   0, 0);

        // Power-on reset state
        #2;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst commit", 64'(out_commit), 64'd0);
        check("rst wen", 64'(out_wb_reg_wen), 64'd0);
        check("rst sel", 64'(out_wb_valD_sel), 64'(WB_VALD_SEL_VALE));
        check("rst bubble", 64'(bubble_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Inputs set at negedge, outputs sampled 1 time unit later, state advances at the next posedge.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vec[i].fl, vec[i].iv, vec[i].ordy, vec[i].pc, vec[i].wen, vec[i].rd);
            #1;
            check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vec[i].ev));
            check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vec[i].eir));
            check($sformatf("v%0d commit", i), 64'(out_commit), 64'(vec[i].ecm));
            check($sformatf("v%0d wb_wen", i), 64'(out_wb_reg_wen), 64'(vec[i].ewen));
            if (vec[i].ev) begin
                check($sformatf("v%0d pc", i), out_pc, vec[i].epc);
                check($sformatf("v%0d rd", i), 64'(out_wb_rd), 64'(vec[i].erd));
                check($sformatf("v%0d instr", i), 64'(out_instr), 64'(f_instr(vec[i].epc)));
                check($sformatf("v%0d pre_pc", i), out_pre_pc, f_pre(vec[i].epc));
                check($sformatf("v%0d valE", i), out_valE, f_vale(vec[i].epc));
                check($sformatf("v%0d valM", i), out_valM, f_valm(vec[i].epc));
                check($sformatf("v%0d sel", i), 64'(out_wb_valD_sel), 64'(f_sel(vec[i].epc)));
            end
        end

        // Fill both slots, then reset asynchronously mid-cycle
        @(negedge clk);
        drive(0, 1, 0, 64'h600, 1, 9);
        @(negedge clk);
        drive(0, 1, 0, 64'h604, 1, 9);
        @(negedge clk);
        drive(0, 0, 0, 64'h0, 0, 0);
        #1;
        check("stall full in_ready", 64'(in_ready), 64'd0);
        check("stall full pc", out_pc, 64'h600);
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst in_ready", 64'(in_ready), 64'd1);
        check("async rst bubble", 64'(bubble_cnt), 64'd0);
        check("async rst instr", 64'(out_instr), 64'd0);
        check("async rst pre_pc", out_pre_pc, 64'd0);
        check("async rst pc", out_pc, 64'd0);
        check("async rst sel", 64'(out_wb_valD_sel), 64'(WB_VALD_SEL_VALE));
        @(posedge clk);
        #1;
        check("rst next out_valid", 64'(out_valid), 64'd0);
        check("rst next in_ready", 64'(in_ready), 64'd1);
        check("rst next bubble", 64'(bubble_cnt), 64'd0);
        check("rst next instr", 64'(out_instr), 64'd0);
        check("rst next pre_pc", out_pre_pc, 64'd0);

        // Idle 20 cycles: wide counter reads 20, 4-bit counter saturates at 15
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("bubble 32b", 64'(bubble_cnt), 64'd20);
        check("bubble 4b sat", 64'(bubble_cnt4), 64'd15);
        repeat (3) @(posedge clk);
        #1;
        check("bubble 4b hold", 64'(bubble_cnt4), 64'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
